// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder: device address byte, then two bytes carrying a register address and 9-bit data.
// Define I2C_RESP_GLITCH_FILTER_EN to insert a 3-sample majority filter on the synchronized SCL/SDA.
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NREG     = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    output logic       o_err,
    output logic       o_busy,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_A  = 3'd2,
        BYTE1  = 3'd3,
        ACK_1  = 3'd4,
        BYTE2  = 3'd5,
        ACK_2  = 3'd6,
        IGNORE = 3'd7
    } state_t;

    localparam logic [6:0] LAST_REG = 7'(NREG - 1);
    localparam logic [7:0] NREG_W   = 8'(NREG);

    state_t     state, next_state;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_f, sda_f, scl_p, sda_p;
    logic       scl_rise, scl_fall, start, stop;
    logic [2:0] bit_cnt;
    logic [7:0] shift_q, byte1_q, rx_byte;
    logic       byte_done, ack_end, commit, abort, out_of_range;
    logic       in_frame, is_ack;
    logic       sda_oe_q, busy_q, wr_valid_q, err_q;
    logic [6:0] wr_addr_q;
    logic [8:0] wr_data_q;
    logic [8:0] regs [NREG];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i_scl};
            sda_sync <= {sda_sync[0], i_sda};
        end
    end

`ifdef I2C_RESP_GLITCH_FILTER_EN
    // Majority of the current and two previous synchronized samples; a single-cycle pulse never wins.
    logic [1:0] scl_hist, sda_hist;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
        end
    end
    assign scl_f = (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
    assign sda_f = (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    // START/STOP require SCL high on both samples so a simultaneous SCL/SDA change is not a condition.
    assign scl_rise = scl_f & ~scl_p;
    assign scl_fall = ~scl_f & scl_p;
    assign start    = scl_f & scl_p & sda_p & ~sda_f;
    assign stop     = scl_f & scl_p & ~sda_p & sda_f;

    assign in_frame     = (state == BYTE1) || (state == ACK_1) || (state == BYTE2) || (state == ACK_2);
    assign is_ack       = (state == ACK_A) || (state == ACK_1) || (state == ACK_2);
    assign out_of_range = {1'b0, byte1_q[7:1]} >= NREG_W;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        rx_byte    = {shift_q[6:0], sda_f};
        byte_done  = scl_rise && (bit_cnt == 3'd7);
        ack_end    = is_ack && scl_fall && sda_oe_q;
        commit     = 1'b0;
        abort      = (start || stop) && in_frame;
        if (start) begin
            next_state = ADDR;
        end else if (stop) begin
            next_state = IDLE;
        end else begin
            case (state)
                ADDR:    if (byte_done) next_state = (rx_byte == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                ACK_A:   if (ack_end) next_state = BYTE1;
                BYTE1:   if (byte_done) next_state = ACK_1;
                ACK_1:   if (ack_end) next_state = BYTE2;
                BYTE2:   if (byte_done) next_state = ACK_2;
                ACK_2: begin
                    if (ack_end) begin
                        next_state = IGNORE;
                        commit     = 1'b1;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    // The second data byte stays in shift_q through ACK_2 because nothing shifts during an ACK.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_cnt    <= '0;
            shift_q    <= '0;
            byte1_q    <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            if (start) begin
                bit_cnt <= '0;
            end else if (scl_rise && (state == ADDR || state == BYTE1 || state == BYTE2)) begin
                shift_q <= rx_byte;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == BYTE1 && byte_done && !start && !stop) byte1_q <= rx_byte;

            if (start || stop || !is_ack) sda_oe_q <= 1'b0;
            else if (scl_fall)            sda_oe_q <= ~sda_oe_q;

            if (start || stop || state == IDLE)           busy_q <= 1'b0;
            else if (state == ADDR && next_state == ACK_A) busy_q <= 1'b1;

            wr_valid_q <= commit;
            err_q      <= abort || (commit && out_of_range);
            if (commit) begin
                wr_addr_q <= byte1_q[7:1];
                wr_data_q <= {byte1_q[0], shift_q};
            end
        end
    end

    // The register file updates one cycle after the commit pulse, so a same-cycle read shows the old value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_valid_q) begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_addr_q == LAST_REG)    regs[i] <= '0;
                else if (wr_addr_q == 7'(i))  regs[i] <= wr_data_q;
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if ({28'd0, i_rd_addr} == 32'(i)) o_rd_data = regs[i];
        end
    end

    assign o_sda_oe   = sda_oe_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_err      = err_q;
    assign o_busy     = busy_q;
    assign o_state    = state;

endmodule
